slice_ff_bank_ctrl: RTL and testbench
=====================================

// Module: slice_ff_bank_ctrl
// PURPOSE
//  Sequences the control pins (CE, LSR, DI, GSR) of a bank of SLICE flip-flops and shares the bank between NREQ requesters.
//  Runs a power-up GSR hold, then round-robin arbitrates LOAD / SET / CLEAR ops.
//  Holds LSR for a programmable pulse plus settle time, so register config (REGSET, SRMODE, LSRMODE) is exercised deterministically on hardware.
//  Sits between the fuzz/test harness requesters and the FF bank under test.
// PARAMETERS
//  WIDTH     8  FFs in the bank (bits of ff_di)
//  NREQ      2  requester count (2..4)
//  GSR_CYC   8  cycles ff_gsr_n held low after rst_n release
//  HOLD_CYC  3  cycles ff_lsr held high for SET/CLEAR (>=1)
//  SETTLE_CYC 2 idle cycles after LSR release before the next grant (>=0)
// PORTS
//  clk        in   1            single clock, rising edge
//  rst_n      in   1            asynchronous active-low reset
//  req_valid  in   NREQ         per-requester op request
//  req_op     in   2*NREQ       per-requester op: 00 NOP, 01 LOAD, 10 SET, 11 CLEAR
//  req_data   in   WIDTH*NREQ   per-requester LOAD data
//  req_ready  out  NREQ         one-hot accept; op taken when valid&ready
//  done       out  1            1-cycle pulse when the granted op completes
//  done_id    out  $clog2(NREQ) requester index for done
//  busy       out  1            high from accept to end of settle
//  ff_gsr_n   out  1            global set/reset to bank, active low
//  ff_ce      out  1            clock enable to bank
//  ff_lsr     out  1            local set/reset to bank
//  ff_lsr_val out  1            REGSET selector: 1 SET, 0 RESET
//  ff_di      out  WIDTH        data to bank D inputs
// BEHAVIOUR
//  Reset (rst_n=0, async):
//   - all outputs 0 (ff_gsr_n=0, req_ready=0, done=0, ff_di=0)
//   - state=GSR_HOLD, rr pointer=0
//  Rst_n mid-op: immediately aborts; no done pulse; full GSR sequence reruns.
//  FSM states:
//   - GSR_HOLD: ff_gsr_n=0 for GSR_CYC cycles after reset release, then ff_gsr_n=1 permanently -> IDLE
//   - IDLE:
//     - req_ready one-hot to the first valid requester at or after rr pointer
//     - NOP ops are ignored (treated as not valid)
//     - accept -> EXEC, latch id/op/data, rr pointer := id+1 mod NREQ
//   - EXEC, LOAD: ff_di=data, ff_ce=1 for exactly 1 cycle -> SETTLE
//   - EXEC, SET/CLEAR:
//     - ff_lsr=1, ff_lsr_val=(op==SET), ff_ce=0 for HOLD_CYC cycles -> SETTLE
//     - ff_lsr_val is stable from the first LSR cycle through 1 cycle after ff_lsr falls
//   - SETTLE: all bank controls 0 for SETTLE_CYC cycles; done pulses on the last cycle (or on exit of EXEC when SETTLE_CYC=0) -> IDLE
//  req_ready rules:
//   - req_ready is combinational from IDLE state and req_valid
//   - never asserted outside IDLE
//   - at most one bit set
//  Latency, accept to done:
//   - LOAD: 1+SETTLE_CYC cycles
//   - SET/CLEAR: HOLD_CYC+SETTLE_CYC cycles
//   - minimum 1
//  Back-to-back: the next accept can happen in the cycle after done.
//  Requester dropping valid while not granted: no effect; no pending state is kept.
//  Fairness: a continuously valid requester is granted within NREQ grants.
//  Counters: one shared down-counter, width $clog2(max(GSR_CYC,HOLD_CYC,SETTLE_CYC)+1); it never wraps, reloaded on each state entry.
// STRUCTURE
//  Package slice_ff_pkg:
//   - typedef ff_op_e {OP_NOP,OP_LOAD,OP_SET,OP_CLEAR}
//   - typedef ctrl_state_e {GSR_HOLD,IDLE,EXEC,SETTLE}
//  Sub-module rr_arbiter #(N): valid vector + pointer -> one-hot grant, combinational.
//  All else is flat in this module.
// TESTING
//  1 Reset release, no requests:
//    - ff_gsr_n=0 for exactly 8 cycles, then 1
//    - no req_ready during that time
//  2 Req0 LOAD 0xA5:
//    - ready same cycle in IDLE
//    - ff_ce=1 with ff_di=0xA5 for 1 cycle
//    - done (id 0) 3 cycles after accept
//  3 Req1 SET:
//    - ff_lsr=1 and ff_lsr_val=1 for 3 cycles, ce=0
//    - 2 settle cycles, then done_id=1
//  4 Both requesters continuously valid (LOAD/CLEAR): grants alternate 0,1,0,1; none starved over 8 ops.
//  5 rst_n low during SET hold cycle 2:
//    - ff_lsr=0 immediately, no done
//    - GSR sequence repeats
//  6 Req0 op NOP with valid=1, req1 LOAD: req1 granted; req0 never gets ready.

Source files
------------

// File: rtl/slice_ff_bank_ctrl_pkg.sv
// Shared types and helpers for the SLICE flip-flop bank controller.
// Op encodings match the requester bus: 00 NOP, 01 LOAD, 10 SET, 11 CLEAR.
package slice_ff_pkg;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_LOAD  = 2'b01,
    OP_SET   = 2'b10,
    OP_CLEAR = 2'b11
  } ff_op_e;

  typedef enum logic [1:0] {
    GSR_HOLD,
    IDLE,
    EXEC,
    SETTLE
  } ctrl_state_e;

  // Sizes the shared down-counter so it can hold the longest phase length.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/slice_ff_bank_ctrl_if.sv
// Requester-side bus of the FF bank controller: request/ready handshake plus completion status.
interface slice_ff_bank_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 2
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]       req_valid;
  logic [2*NREQ-1:0]     req_op;
  logic [WIDTH*NREQ-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  done;
  logic [IDW-1:0]        done_id;
  logic                  busy;

  modport master (
    output req_valid, req_op, req_data,
    input  req_ready, done, done_id, busy
  );

  modport slave (
    input  req_valid, req_op, req_data,
    output req_ready, done, done_id, busy
  );
endinterface

// File: rtl/slice_ff_bank_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first valid requester at or after ptr.
module rr_arbiter
  import slice_ff_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]         valid,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant
);
  localparam int PW = $clog2(N);

  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(ptr) + i) % N);
      if (!found && valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/slice_ff_bank_ctrl.sv
// Sequences GSR/CE/LSR/DI of a SLICE FF bank and shares it round-robin between requesters.
module slice_ff_bank_ctrl
  import slice_ff_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int NREQ       = 2,
  parameter int GSR_CYC    = 8,
  parameter int HOLD_CYC   = 3,
  parameter int SETTLE_CYC = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  slice_ff_bank_ctrl_if.slave  bus,
  output logic                 ff_gsr_n,
  output logic                 ff_ce,
  output logic                 ff_lsr,
  output logic                 ff_lsr_val,
  output logic [WIDTH-1:0]     ff_di
);
  localparam int IW    = $clog2(NREQ);
  localparam int CNT_W = $clog2(max3(GSR_CYC, HOLD_CYC, SETTLE_CYC) + 1);

  ctrl_state_e      state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [IW-1:0]    ptr, id_q, grant_id;
  ff_op_e           op_q, sel_op;
  logic [WIDTH-1:0] data_q, sel_data;
  logic             lsr_tail, lsr_tail_nx;
  logic             accept;
  logic [NREQ-1:0]  eff_valid, grant;

  // NOP requests are invisible to the arbiter; the chosen requester's op/data are muxed out.
  always_comb begin
    eff_valid = '0;
    grant_id  = '0;
    sel_op    = OP_NOP;
    sel_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      eff_valid[i] = bus.req_valid[i] && (bus.req_op[2*i +: 2] != 2'b00);
      if (grant[i]) begin
        grant_id = IW'(i);
        sel_op   = ff_op_e'(bus.req_op[2*i +: 2]);
        sel_data = bus.req_data[WIDTH*i +: WIDTH];
      end
    end
  end

  rr_arbiter #(.N(NREQ)) u_arb (
    .valid (eff_valid),
    .ptr   (ptr),
    .grant (grant)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= GSR_HOLD;
      cnt      <= CNT_W'(GSR_CYC - 1);
      ptr      <= '0;
      id_q     <= '0;
      op_q     <= OP_NOP;
      data_q   <= '0;
      lsr_tail <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      lsr_tail <= lsr_tail_nx;
      if (accept) begin
        id_q   <= grant_id;
        op_q   <= sel_op;
        data_q <= sel_data;
        ptr    <= (grant_id == IW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
      end
    end
  end

  // lsr_tail keeps the REGSET selector valid for one cycle after LSR drops.
  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    lsr_tail_nx   = 1'b0;
    accept        = 1'b0;
    ff_gsr_n      = 1'b1;
    ff_ce         = 1'b0;
    ff_lsr        = 1'b0;
    ff_di         = '0;
    bus.req_ready = '0;
    bus.done      = 1'b0;
    bus.busy      = 1'b0;
    case (state)
      GSR_HOLD: begin
        ff_gsr_n = 1'b0;
        if (cnt == '0) state_nx = IDLE;
        else           cnt_nx   = cnt - 1'b1;
      end
      IDLE: begin
        bus.req_ready = grant;
        if (|grant) begin
          accept   = 1'b1;
          state_nx = EXEC;
          cnt_nx   = (sel_op == OP_LOAD) ? '0 : CNT_W'(HOLD_CYC - 1);
        end
      end
      EXEC: begin
        bus.busy = 1'b1;
        if (op_q == OP_LOAD) begin
          ff_ce = 1'b1;
          ff_di = data_q;
        end else begin
          ff_lsr = 1'b1;
        end
        if (cnt == '0) begin
          lsr_tail_nx = (op_q != OP_LOAD);
          if (SETTLE_CYC == 0) begin
            bus.done = 1'b1;
            state_nx = IDLE;
          end else begin
            state_nx = SETTLE;
            cnt_nx   = CNT_W'(SETTLE_CYC - 1);
          end
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      SETTLE: begin
        bus.busy = 1'b1;
        if (cnt == '0) begin
          bus.done = 1'b1;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      default: state_nx = GSR_HOLD;
    endcase
    ff_lsr_val  = (op_q == OP_SET) && (ff_lsr || lsr_tail);
    bus.done_id = bus.done ? id_q : '0;
  end
endmodule

// File: tb/tb_slice_ff_bank_ctrl.sv
// Directed bench for slice_ff_bank_ctrl: GSR sequence, LOAD/SET/CLEAR timing, round-robin, reset abort, NOP masking.
module tb_slice_ff_bank_ctrl;
  logic       clk;
  logic       rst_n;
  logic       ff_gsr_n, ff_ce, ff_lsr, ff_lsr_val;
  logic [7:0] ff_di;
  int         vectors;
  int         miscompares;
  int         grants0, grants1;

  slice_ff_bank_ctrl_if #(.WIDTH(8), .NREQ(2)) bus ();

  slice_ff_bank_ctrl #(
    .WIDTH(8), .NREQ(2), .GSR_CYC(8), .HOLD_CYC(3), .SETTLE_CYC(2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .ff_gsr_n   (ff_gsr_n),
    .ff_ce      (ff_ce),
    .ff_lsr     (ff_lsr),
    .ff_lsr_val (ff_lsr_val),
    .ff_di      (ff_di)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] valid, input logic [3:0] op, input logic [15:0] data);
    bus.req_valid = valid;
    bus.req_op    = op;
    bus.req_data  = data;
  endtask

  // Called in the first cycle after reset release; ends in the first IDLE cycle.
  task automatic gsrSequence(input string tag);
    #1;
    checkOutput({tag, "_gsr_lo"}, ff_gsr_n, 0);
    checkOutput({tag, "_rdy_lo"}, bus.req_ready, 0);
    for (int i = 1; i < 8; i++) begin
      @(posedge clk); #2;
      checkOutput({tag, "_gsr_lo"}, ff_gsr_n, 0);
      checkOutput({tag, "_rdy_lo"}, bus.req_ready, 0);
    end
    @(posedge clk); #2;
    checkOutput({tag, "_gsr_hi"}, ff_gsr_n, 1);
  endtask

  task automatic runToDone(input string tag, input int expId, input logic [7:0] expDi, input logic expLsrVal);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 12 && !seen; c++) begin
      @(posedge clk); #2;
      checkOutput({tag, "_ready"}, bus.req_ready, 0);
      if (ff_ce)  checkOutput({tag, "_di"}, ff_di, expDi);
      if (ff_lsr) checkOutput({tag, "_lsrval"}, ff_lsr_val, expLsrVal);
      if (bus.done) begin
        seen = 1'b1;
        checkOutput({tag, "_id"}, bus.done_id, expId);
      end
    end
    checkOutput({tag, "_done"}, seen, 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    grants0     = 0;
    grants1     = 0;
    rst_n       = 1'b0;
    applyStimulus(2'b00, 4'h0, 16'h0);

    // Reset values, then the GSR hold with no requests
    repeat (3) @(posedge clk);
    #2;
    checkOutput("rst_gsr", ff_gsr_n, 0);
    checkOutput("rst_ce", ff_ce, 0);
    checkOutput("rst_lsr", ff_lsr, 0);
    checkOutput("rst_lsrval", ff_lsr_val, 0);
    checkOutput("rst_di", ff_di, 0);
    checkOutput("rst_ready", bus.req_ready, 0);
    checkOutput("rst_done", bus.done, 0);
    checkOutput("rst_busy", bus.busy, 0);
    @(negedge clk) rst_n = 1'b1;
    gsrSequence("t1");

    // Req0 LOAD 0xA5
    applyStimulus(2'b01, {2'b00, 2'b01}, {8'h00, 8'hA5});
    #1 checkOutput("t2_ready", bus.req_ready, 2'b01);
    @(posedge clk); #2;
    applyStimulus(2'b00, 4'h0, 16'h0);
    checkOutput("t2_ce", ff_ce, 1);
    checkOutput("t2_di", ff_di, 8'hA5);
    checkOutput("t2_busy", bus.busy, 1);
    checkOutput("t2_done_early", bus.done, 0);
    @(posedge clk); #2;
    checkOutput("t2_ce_off", ff_ce, 0);
    checkOutput("t2_di_off", ff_di, 0);
    checkOutput("t2_done_s1", bus.done, 0);
    @(posedge clk); #2;
    checkOutput("t2_done", bus.done, 1);
    checkOutput("t2_done_id", bus.done_id, 0);
    @(posedge clk); #2;
    checkOutput("t2_done_clr", bus.done, 0);

    // Req1 SET: 3 hold cycles, selector held one extra cycle, then 2 settle
    applyStimulus(2'b10, {2'b10, 2'b00}, 16'h0);
    #1 checkOutput("t3_ready", bus.req_ready, 2'b10);
    for (int h = 0; h < 3; h++) begin
      @(posedge clk); #2;
      if (h == 0) applyStimulus(2'b00, 4'h0, 16'h0);
      checkOutput("t3_lsr", ff_lsr, 1);
      checkOutput("t3_lsrval", ff_lsr_val, 1);
      checkOutput("t3_ce", ff_ce, 0);
      checkOutput("t3_done_early", bus.done, 0);
    end
    @(posedge clk); #2;
    checkOutput("t3_lsr_off", ff_lsr, 0);
    checkOutput("t3_lsrval_tail", ff_lsr_val, 1);
    checkOutput("t3_done_s1", bus.done, 0);
    @(posedge clk); #2;
    checkOutput("t3_done", bus.done, 1);
    checkOutput("t3_done_id", bus.done_id, 1);
    checkOutput("t3_lsrval_off", ff_lsr_val, 0);
    @(posedge clk); #2;

    // Both continuously valid: req0 LOAD 0x3C, req1 CLEAR; grants must alternate
    applyStimulus(2'b11, {2'b11, 2'b01}, {8'h00, 8'h3C});
    for (int k = 0; k < 8; k++) begin
      #1 checkOutput("t4_ready", bus.req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      if (bus.req_ready == 2'b01) grants0++;
      if (bus.req_ready == 2'b10) grants1++;
      runToDone("t4", k % 2, 8'h3C, 1'b0);
      @(posedge clk); #2;
    end
    checkOutput("t4_grants0", grants0, 4);
    checkOutput("t4_grants1", grants1, 4);

    // Reset asserted during the second SET hold cycle aborts the op
    applyStimulus(2'b10, {2'b10, 2'b00}, 16'h0);
    #1 checkOutput("t5_ready", bus.req_ready, 2'b10);
    @(posedge clk); #2;
    applyStimulus(2'b00, 4'h0, 16'h0);
    checkOutput("t5_lsr_h1", ff_lsr, 1);
    @(posedge clk); #2;
    checkOutput("t5_lsr_h2", ff_lsr, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("t5_lsr_abort", ff_lsr, 0);
    checkOutput("t5_lsrval_abort", ff_lsr_val, 0);
    checkOutput("t5_gsr_abort", ff_gsr_n, 0);
    checkOutput("t5_busy_abort", bus.busy, 0);
    checkOutput("t5_done_abort", bus.done, 0);
    repeat (2) begin
      @(posedge clk); #2;
      checkOutput("t5_done_in_rst", bus.done, 0);
    end
    applyStimulus(2'b01, {2'b00, 2'b01}, {8'h00, 8'h5A});
    @(negedge clk) rst_n = 1'b1;
    gsrSequence("t5");
    #1 checkOutput("t5_ready_post", bus.req_ready, 2'b01);
    runToDone("t5_load", 0, 8'h5A, 1'b0);
    @(posedge clk); #2;

    // Req0 valid with NOP must never be granted, whatever the pointer
    applyStimulus(2'b11, {2'b01, 2'b00}, {8'h81, 8'h00});
    #1 checkOutput("t6_ready_a", bus.req_ready, 2'b10);
    runToDone("t6a", 1, 8'h81, 1'b0);
    @(posedge clk); #2;
    #1 checkOutput("t6_ready_b", bus.req_ready, 2'b10);
    runToDone("t6b", 1, 8'h81, 1'b0);
    @(posedge clk); #2;
    applyStimulus(2'b00, 4'h0, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
